uart_tx_fifo_ctrl: RTL and testbench

Byte buffer and send scheduler that sits directly upstream of the UART transmitter. It accepts bytes from a producer in single-cycle writes and stores them in a FIFO. It presents one byte at a time to the transmitter as a start edge plus stable data, then waits for the transmitter's done pulse before releasing the next byte. A watchdog recovers the block if the done pulse never arrives.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, timing constants and a
// counter-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP
    } tx_state_e;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned BAUD       = 115200;
    localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;

    // Bits needed to hold the values 0..n; never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a one-cycle overflow pulse.
// Writes seen while full are dropped, even when a read happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, ovf_q;
    logic             wr_acc, rd_acc;

    always_comb begin
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            ovf_q    <= wr_en & full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte buffer and send scheduler in front of the UART transmitter: pops one byte at a
// time, holds tx_start, waits for tx_done (with a watchdog) and enforces an idle gap.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned START_HOLD     = 2,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 5208
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              tx_err
);

    localparam int unsigned HOLD_W   = cnt_width(START_HOLD);
    localparam int unsigned GAP_W    = cnt_width(GAP_CYCLES);
    localparam int unsigned WD_W     = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam int unsigned WD_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    tx_state_e         state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_err_q, tx_err_d;
    logic              pop;
    logic [7:0]        fifo_rd_data;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        wd_d     = wd_q;
        tx_err_d = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = '0;
                    state_d = ST_START;
                end
            end
            // START lasts START_HOLD+1 cycles so the registered tx_start is high START_HOLD.
            ST_START: begin
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (hold_q == HOLD_W'(START_HOLD)) begin
                    wd_d    = '0;
                    state_d = ST_WAIT;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (wd_q == WD_W'(WD_LAST)) begin
                    tx_err_d = 1'b1;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tx_start_d = (state_q == ST_START) && (state_d == ST_START);
        tx_data_d  = pop ? fifo_rd_data : tx_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            gap_q      <= '0;
            wd_q       <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            wd_q       <= wd_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_err   = tx_err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed self-checking bench for uart_tx_fifo_ctrl; a small hand-driven transmitter
// model returns tx_done at chosen times.
module tb_uart_tx_fifo_ctrl;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned START_HOLD = 2;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 5208;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            tx_done = 1'b0;
    logic            full, empty, ovf, tx_start, busy, tx_err;
    logic [ADDR_W:0] count;
    logic [7:0]      tx_data;

    int n_checks = 0;
    int n_pass   = 0;
    int rise_cnt = 0;
    int err_cnt  = 0;
    logic start_prev = 1'b0;

    always #10 clk = ~clk;

    uart_tx_fifo_ctrl #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .START_HOLD     (START_HOLD),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .tx_err   (tx_err)
    );

    // Count tx_start rising edges and tx_err high cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_start === 1'b1 && start_prev !== 1'b1) rise_cnt++;
        if (tx_err === 1'b1) err_cnt++;
        start_prev = tx_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Edges until tx_data first changes (pop) and until tx_start is seen high (rise).
    task automatic wait_start(input int budget, output int n_pop, output int n_rise);
        logic [7:0] d0;
        int i;
        d0     = tx_data;
        n_pop  = -1;
        n_rise = -1;
        i      = 0;
        while (n_rise < 0 && i < budget) begin
            tick();
            i++;
            if (n_pop < 0 && tx_data !== d0) n_pop = i;
            if (tx_start === 1'b1) n_rise = i;
        end
    endtask

    task automatic wait_idle(input int budget, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < budget) begin
            tick();
            i++;
            if (busy === 1'b0) n = i;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({tx_start, tx_data, busy} !== {1'b0, 8'h00, 1'b0})
            $display("FAIL reset_tx: start/data/busy got %b/%h/%b want 0/00/0",
                     tx_start, tx_data, busy);
        else n_pass++;
        n_checks++;
        if ({empty, full, ovf, tx_err, count} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0})
            $display("FAIL reset_fifo: empty/full/ovf/err/count got %b/%b/%b/%b/%0d want 1/0/0/0/0",
                     empty, full, ovf, tx_err, count);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int p, r, n;
        write_byte(8'hC9);
        wait_start(10, p, r);
        n_checks++;
        if (r !== 2) $display("FAIL single_latency: got %0d edges want 2", r);
        else n_pass++;
        n_checks++;
        if ({tx_data, busy, empty} !== {8'hC9, 1'b1, 1'b1})
            $display("FAIL single_data: data/busy/empty got %h/%b/%b want c9/1/1",
                     tx_data, busy, empty);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (tx_start !== 1'b0) $display("FAIL single_wait_start_low: got %b want 0", tx_start);
        else n_pass++;
        // tx_done sampled 4340 edges after the rise edge.
        repeat (4336) tick();
        pulse_done();
        n_checks++;
        if ({tx_data, busy, tx_err} !== {8'hC9, 1'b1, 1'b0})
            $display("FAIL single_gap: data/busy/err got %h/%b/%b want c9/1/0",
                     tx_data, busy, tx_err);
        else n_pass++;
        wait_idle(20, n);
        n_checks++;
        if (n !== GAP_CYCLES) $display("FAIL single_gap_len: got %0d want %0d", n, GAP_CYCLES);
        else n_pass++;
    endtask

    task automatic test_burst();
        int p, r, n, r0;
        r0 = rise_cnt;
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        n_checks++;
        if ({full, count} !== {1'b0, 5'd4})
            $display("FAIL burst_count: full/count got %b/%0d want 0/4", full, count);
        else n_pass++;
        n_checks++;
        if ({tx_data, busy} !== {8'h01, 1'b1})
            $display("FAIL burst_first: data/busy got %h/%b want 01/1", tx_data, busy);
        else n_pass++;
        for (int i = 2; i <= 5; i++) begin
            repeat (10) tick();
            pulse_done();
            wait_start(20, p, r);
            n_checks++;
            if ({tx_data, 32'(p), 32'(r)} !== {8'(i), 32'(GAP_CYCLES + 1), 32'(GAP_CYCLES + 2)})
                $display("FAIL burst_byte%0d: data/pop/rise got %h/%0d/%0d want %h/%0d/%0d",
                         i, tx_data, p, r, 8'(i), GAP_CYCLES + 1, GAP_CYCLES + 2);
            else n_pass++;
        end
        repeat (10) tick();
        pulse_done();
        wait_idle(20, n);
        n_checks++;
        if (rise_cnt - r0 !== 5) $display("FAIL burst_rises: got %0d want 5", rise_cnt - r0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int p, r, n, e0;
        e0 = err_cnt;
        write_byte(8'hAA);
        write_byte(8'hBB);
        wait_start(10, p, r);
        n_checks++;
        if ({tx_data, 32'(r)} !== {8'hAA, 32'd1})
            $display("FAIL timeout_first: data/rise got %h/%0d want aa/1", tx_data, r);
        else n_pass++;
        n = 0;
        while (tx_start === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        // Now on the WAIT entry edge; count edges to tx_err.
        n = 0;
        while (tx_err !== 1'b1 && n < TIMEOUT + 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== TIMEOUT) $display("FAIL timeout_len: got %0d want %0d", n, TIMEOUT);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL timeout_busy: got %b want 1", busy);
        else n_pass++;
        wait_start(20, p, r);
        n_checks++;
        if ({tx_data, 32'(r)} !== {8'hBB, 32'(GAP_CYCLES + 2)})
            $display("FAIL timeout_next: data/rise got %h/%0d want bb/%0d", tx_data, r,
                     GAP_CYCLES + 2);
        else n_pass++;
        repeat (5) tick();
        pulse_done();
        wait_idle(20, n);
        n_checks++;
        if ({32'(err_cnt - e0), empty, busy} !== {32'd1, 1'b1, 1'b0})
            $display("FAIL timeout_end: errcycles/empty/busy got %0d/%b/%b want 1/1/0",
                     err_cnt - e0, empty, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int r0;
        for (int i = 0; i < 4; i++) write_byte(8'(8'h31 + i));
        n_checks++;
        if ({tx_start, count} !== {1'b1, 5'd3})
            $display("FAIL rstmid_pre: start/count got %b/%0d want 1/3", tx_start, count);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_start, count, empty, tx_data, busy} !== {1'b0, 5'd0, 1'b1, 8'h00, 1'b0})
            $display("FAIL rstmid_async: start/count/empty/data/busy got %b/%0d/%b/%h/%b want 0/0/1/00/0",
                     tx_start, count, empty, tx_data, busy);
        else n_pass++;
        r0 = rise_cnt;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        repeat (5) tick();
        n_checks++;
        if ({32'(rise_cnt - r0), count, empty} !== {32'd0, 5'd0, 1'b1})
            $display("FAIL rstmid_hold: rises/count/empty got %0d/%0d/%b want 0/0/1",
                     rise_cnt - r0, count, empty);
        else n_pass++;
        wr_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy, count, tx_start} !== {1'b0, 5'd0, 1'b0})
            $display("FAIL rstmid_after: busy/count/start got %b/%0d/%b want 0/0/0",
                     busy, count, tx_start);
        else n_pass++;
    endtask

    task automatic test_overflow();
        // The first byte is popped right away, so 17 writes are accepted before full.
        for (int i = 0; i < 18; i++) begin
            write_byte(8'(8'h10 + i));
            if (i == 15) begin
                n_checks++;
                if ({full, count} !== {1'b0, 5'd15})
                    $display("FAIL ovf_15: full/count got %b/%0d want 0/15", full, count);
                else n_pass++;
            end else if (i == 16) begin
                n_checks++;
                if ({full, count, ovf} !== {1'b1, 5'd16, 1'b0})
                    $display("FAIL ovf_full: full/count/ovf got %b/%0d/%b want 1/16/0",
                             full, count, ovf);
                else n_pass++;
            end else if (i == 17) begin
                n_checks++;
                if ({count, ovf} !== {5'd16, 1'b1})
                    $display("FAIL ovf_drop: count/ovf got %0d/%b want 16/1", count, ovf);
                else n_pass++;
            end
        end
        tick();
        n_checks++;
        if ({ovf, tx_data, busy} !== {1'b0, 8'h10, 1'b1})
            $display("FAIL ovf_after: ovf/data/busy got %b/%h/%b want 0/10/1", ovf, tx_data, busy);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        int p, r, n, r0;
        pulse_done();
        wait_idle(10, n);
        n_checks++;
        if ({full, count} !== {1'b1, 5'd16})
            $display("FAIL fullpop_pre: full/count got %b/%0d want 1/16", full, count);
        else n_pass++;
        write_byte(8'hC9);
        n_checks++;
        if ({ovf, count, full, tx_data} !== {1'b1, 5'd15, 1'b0, 8'h11})
            $display("FAIL fullpop_drop: ovf/count/full/data got %b/%0d/%b/%h want 1/15/0/11",
                     ovf, count, full, tx_data);
        else n_pass++;
        r0 = rise_cnt;
        for (int i = 1; i <= 16; i++) begin
            wait_start(20, p, r);
            n_checks++;
            if (r < 0 || tx_data !== 8'(8'h10 + i))
                $display("FAIL drain_byte%0d: data/rise got %h/%0d want %h/>0",
                         i, tx_data, r, 8'(8'h10 + i));
            else n_pass++;
            repeat (5) tick();
            pulse_done();
        end
        wait_idle(20, n);
        repeat (20) tick();
        n_checks++;
        if ({32'(rise_cnt - r0), empty, count, busy} !== {32'd16, 1'b1, 5'd0, 1'b0})
            $display("FAIL drain_end: rises/empty/count/busy got %0d/%b/%0d/%b want 16/1/0/0",
                     rise_cnt - r0, empty, count, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_reset_mid();
        test_overflow();
        test_full_pop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
